// File: rtl/commit_trace_queue.sv
// commit_trace_queue: cycle-stamped retire/CSR trace collector with all-or-nothing group enqueue.
module commit_trace_queue #(
  parameter int RETIRE_WIDTH = 3,
  parameter int ADDR_BITS = 40,
  parameter int XLEN = 64,
  parameter int DEPTH = 16,
  parameter int DROP_BITS = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [RETIRE_WIDTH-1:0]        commit_valid,
  input  logic [RETIRE_WIDTH*ADDR_BITS-1:0] commit_pc,
  input  logic [RETIRE_WIDTH*32-1:0]     commit_inst,
  input  logic [RETIRE_WIDTH*3-1:0]      commit_rtype,
  input  logic [RETIRE_WIDTH*6-1:0]      commit_ldst,
  input  logic [RETIRE_WIDTH*XLEN-1:0]   commit_wdata,
  input  logic [2:0]                     csr_cmd,
  input  logic [11:0]                    csr_addr,
  input  logic [XLEN-1:0]                csr_wdata,
  input  logic [XLEN-1:0]                csr_rdata,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_kind,
  output logic [63:0]                    out_cycle,
  output logic [ADDR_BITS-1:0]           out_pc,
  output logic [31:0]                    out_inst,
  output logic [2:0]                     out_rtype,
  output logic [11:0]                    out_addr,
  output logic [XLEN-1:0]                out_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           overflow,
  output logic [DROP_BITS-1:0]           drop_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int GW = $clog2(RETIRE_WIDTH+2);
  typedef struct packed {
    logic                 kind;
    logic [63:0]          cycle;
    logic [ADDR_BITS-1:0] pc;
    logic [31:0]          inst;
    logic [2:0]           rtype;
    logic [11:0]          addr;
    logic [XLEN-1:0]      data;
  } entry_t;
  entry_t mem [DEPTH];
  logic [63:0] cycle;
  logic [PW-1:0] rptr, wptr;
  logic [GW-1:0] off [RETIRE_WIDTH+1];
  logic [GW-1:0] n;
  logic csr_ev, deq, accept;
  logic [XLEN-1:0] csr_val;
  logic [CW:0] free;
  logic [DROP_BITS:0] dsum;
  assign csr_ev = enable & csr_cmd[2] & (csr_cmd[1:0] != 2'd0);
  assign csr_val = csr_cmd == 3'd6 ? csr_rdata | csr_wdata :
                   csr_cmd == 3'd7 ? csr_rdata & ~csr_wdata : csr_wdata;
  // Each event's slot offset is the number of events ahead of it in the group.
  always_comb begin
    n = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      off[i] = n;
      n = n + GW'(enable & commit_valid[i]);
    end
    off[RETIRE_WIDTH] = n;
    n = n + GW'(csr_ev);
  end
  assign out_valid = count != '0;
  assign full = count == CW'(DEPTH);
  assign deq = out_valid & out_ready;
  assign free = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(deq);
  assign accept = (CW+1)'(n) <= free;
  assign dsum = {1'b0, drop_count} + (DROP_BITS+1)'(n);
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle <= '0;
      rptr <= '0;
      wptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      cycle <= cycle + 64'd1;
      if (deq) rptr <= rptr + PW'(1);
      count <= count + (accept ? CW'(n) : CW'(0)) - CW'(deq);
      if (accept) wptr <= wptr + PW'(n);
      else begin
        overflow <= 1'b1;
        drop_count <= dsum[DROP_BITS] ? '1 : dsum[DROP_BITS-1:0];
      end
    end
  end
  always_ff @(posedge clock) begin
    if (!reset && accept) begin
      for (int i = 0; i < RETIRE_WIDTH; i++)
        if (enable && commit_valid[i])
          mem[wptr + PW'(off[i])] <= '{kind: 1'b0, cycle: cycle,
            pc: commit_pc[i*ADDR_BITS +: ADDR_BITS], inst: commit_inst[i*32 +: 32],
            rtype: commit_rtype[i*3 +: 3], addr: {6'd0, commit_ldst[i*6 +: 6]},
            data: commit_wdata[i*XLEN +: XLEN]};
      if (csr_ev)
        mem[wptr + PW'(off[RETIRE_WIDTH])] <= '{kind: 1'b1, cycle: cycle, pc: '0,
          inst: '0, rtype: '0, addr: csr_addr, data: csr_val};
    end
  end
  assign out_kind = mem[rptr].kind;
  assign out_cycle = mem[rptr].cycle;
  assign out_pc = mem[rptr].pc;
  assign out_inst = mem[rptr].inst;
  assign out_rtype = mem[rptr].rtype;
  assign out_addr = mem[rptr].addr;
  assign out_data = mem[rptr].data;
endmodule

// File: tb/tb_commit_trace_queue.sv
// tb_commit_trace_queue: directed and random stimulus against a queue-based trace model.
module tb_commit_trace_queue;
  localparam int RW = 3, AB = 40, XL = 64, D = 16, DB = 16;
  logic clock = 0, reset = 1, enable = 0, out_ready = 0;
  logic [RW-1:0] commit_valid = '0;
  logic [RW*AB-1:0] commit_pc = '0;
  logic [RW*32-1:0] commit_inst = '0;
  logic [RW*3-1:0] commit_rtype = '0;
  logic [RW*6-1:0] commit_ldst = '0;
  logic [RW*XL-1:0] commit_wdata = '0;
  logic [2:0] csr_cmd = '0;
  logic [11:0] csr_addr = '0;
  logic [XL-1:0] csr_wdata = '0, csr_rdata = '0;
  logic out_valid, out_kind, full, overflow;
  logic [63:0] out_cycle;
  logic [AB-1:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0] out_rtype;
  logic [11:0] out_addr;
  logic [XL-1:0] out_data;
  logic [$clog2(D+1)-1:0] count;
  logic [DB-1:0] drop_count;
  always #5 clock = ~clock;
  commit_trace_queue #(.RETIRE_WIDTH(RW), .ADDR_BITS(AB), .XLEN(XL), .DEPTH(D), .DROP_BITS(DB)) dut (
    .clock(clock), .reset(reset), .enable(enable), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_rtype(commit_rtype),
    .commit_ldst(commit_ldst), .commit_wdata(commit_wdata), .csr_cmd(csr_cmd),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind), .out_cycle(out_cycle),
    .out_pc(out_pc), .out_inst(out_inst), .out_rtype(out_rtype), .out_addr(out_addr),
    .out_data(out_data), .count(count), .full(full), .overflow(overflow), .drop_count(drop_count));
  typedef struct {
    bit kind;
    longint unsigned cyc, pc, data;
    int unsigned inst, rtype, addr;
  } ev_t;
  ev_t q[$];
  longint unsigned mcyc = 0, c2;
  int mdrop = 0, errors = 0, checks = 0;
  bit movf = 0;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Compare outputs against the model, then advance the model by one clock with current inputs.
  task automatic tick(bit cmp);
    ev_t g[$];
    ev_t e;
    bit deq;
    int free;
    #1;
    if (cmp) begin
      check("valid", out_valid, q.size() != 0);
      check("count", count, q.size());
      check("full", full, q.size() == D);
      check("overflow", overflow, movf);
      check("drop", drop_count, mdrop);
      if (q.size() != 0) begin
        check("kind", out_kind, q[0].kind);
        check("cycle", out_cycle, q[0].cyc);
        check("pc", out_pc, q[0].pc);
        check("inst", out_inst, q[0].inst);
        check("rtype", out_rtype, q[0].rtype);
        check("addr", out_addr, q[0].addr);
        check("data", out_data, q[0].data);
      end
    end
    deq = q.size() != 0 && out_ready;
    if (enable) begin
      for (int i = 0; i < RW; i++)
        if (commit_valid[i]) begin
          e.kind = 0; e.cyc = mcyc; e.pc = commit_pc[i*AB +: AB];
          e.inst = commit_inst[i*32 +: 32]; e.rtype = commit_rtype[i*3 +: 3];
          e.addr = commit_ldst[i*6 +: 6]; e.data = commit_wdata[i*XL +: XL];
          g.push_back(e);
        end
      if (csr_cmd >= 3'd5) begin
        e.kind = 1; e.cyc = mcyc; e.pc = 0; e.inst = 0; e.rtype = 0; e.addr = csr_addr;
        e.data = csr_cmd == 3'd5 ? csr_wdata : csr_cmd == 3'd6 ? (csr_rdata | csr_wdata) : (csr_rdata & ~csr_wdata);
        g.push_back(e);
      end
    end
    @(posedge clock);
    if (reset) begin
      q.delete(); mcyc = 0; mdrop = 0; movf = 0;
    end else begin
      free = D - q.size() + int'(deq);
      if (deq) void'(q.pop_front());
      if (g.size() <= free) foreach (g[k]) q.push_back(g[k]);
      else begin
        movf = 1;
        mdrop = (mdrop + g.size() > 65535) ? 65535 : mdrop + g.size();
      end
      mcyc++;
    end
    @(negedge clock);
  endtask
  task automatic port(int i, logic [AB-1:0] pc);
    commit_pc[i*AB +: AB] = pc;
    commit_inst[i*32 +: 32] = $urandom;
    commit_rtype[i*3 +: 3] = 3'($urandom_range(0, 2) == 2 ? 4 : $urandom_range(0, 1));
    commit_ldst[i*6 +: 6] = 6'($urandom);
    commit_wdata[i*XL +: XL] = {$urandom, $urandom};
  endtask
  task automatic rnd_in();
    enable = $urandom_range(0, 9) < 8;
    commit_valid = RW'($urandom);
    for (int i = 0; i < RW; i++) port(i, AB'({$urandom, $urandom}));
    csr_cmd = 3'($urandom);
    csr_addr = 12'($urandom);
    csr_wdata = {$urandom, $urandom};
    csr_rdata = {$urandom, $urandom};
    out_ready = $urandom_range(0, 99) < 60;
  endtask
  initial begin
    @(negedge clock);
    tick(0);
    tick(1);
    reset = 0; enable = 1;
    repeat (10) tick(1);
    commit_valid = 3'b101; port(0, 'h1000); port(2, 'h1008);
    csr_cmd = 6; csr_rdata = 'hF0; csr_wdata = 'h0F; out_ready = 1;
    tick(1);
    commit_valid = 0; csr_cmd = 0;
    check("t1_pc0", out_pc, 'h1000); check("t1_cyc0", out_cycle, 10);
    tick(1);
    check("t1_pc2", out_pc, 'h1008);
    tick(1);
    check("t1_csr", out_data, 'hFF); check("t1_kind", out_kind, 1); check("t1_cyc2", out_cycle, 10);
    tick(1);
    out_ready = 0; commit_valid = 3'b111; csr_cmd = 5; csr_wdata = 'h55;
    port(0, 'h2000); port(1, 'h2004); port(2, 'h2008);
    c2 = mcyc;
    repeat (4) tick(1);
    check("t2_count", count, 16); check("t2_full", full, 1);
    tick(1);
    check("t2_drop", drop_count, 4); check("t2_ovf", overflow, 1);
    check("t2_head", out_pc, 'h2000); check("t2_headcyc", out_cycle, c2);
    out_ready = 1; commit_valid = 3'b001; csr_cmd = 0; port(0, 'h3000);
    tick(1);
    check("t3_count", count, 16); check("t3_pc", out_pc, 'h2004); check("t3_cyc", out_cycle, c2);
    enable = 0;
    repeat (17) tick(1);
    enable = 1; out_ready = 0; commit_valid = 0;
    csr_cmd = 7; csr_rdata = 'hFF; csr_wdata = 'h0F; tick(1);
    csr_cmd = 5; csr_wdata = 'h1234; tick(1);
    csr_cmd = 4; tick(1);
    csr_cmd = 0;
    check("t4_count", count, 2); check("t4_clr", out_data, 'hF0);
    check("t4_pc", out_pc, 0); check("t4_kind", out_kind, 1);
    out_ready = 1; tick(1);
    check("t4_wr", out_data, 'h1234);
    tick(1);
    check("t4_empty", out_valid, 0);
    repeat (100) begin rnd_in(); tick(1); end
    enable = 1; out_ready = 0; commit_valid = 3'b111; csr_cmd = 5;
    repeat (16400) tick(1);
    check("t5_sat", drop_count, 'hFFFF);
    reset = 1; tick(1);
    reset = 0; commit_valid = 3'b001; csr_cmd = 0;
    repeat (7) tick(1);
    commit_valid = 0;
    check("t6_count7", count, 7);
    reset = 1; tick(1);
    reset = 0;
    check("t6_valid", out_valid, 0); check("t6_count", count, 0);
    check("t6_drop", drop_count, 0); check("t6_ovf", overflow, 0);
    commit_valid = 3'b001; port(0, 'h4000); tick(1);
    commit_valid = 0;
    check("t6_cyc", out_cycle, 0); check("t6_pc", out_pc, 'h4000);
    tick(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/commit_trace_queue.md
Name: commit_trace_queue

Overview:
Synthesizable, parametrised commit-trace collector for a BOOM-style core. Every cycle it captures up to RETIRE_WIDTH retire events plus one CSR write/set/clear event, stamps each with a cycle count, and queues them in order in a circular buffer. A single valid/ready port drains the queue to a trace sink, such as a cosim DPI bridge or an off-chip trace port. Overflow is detected per cycle group and counted, so the sink knows when trace is incomplete.

Parameters:
RETIRE_WIDTH, 3, number of commit ports
ADDR_BITS, 40, PC width (coreMaxAddrBits)
XLEN, 64, data width
DEPTH, 16, queue entries; power of two, >= RETIRE_WIDTH+1
DROP_BITS, 16, width of the saturating drop counter

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high
enable  in  1  trace capture enable
commit_valid  in  RETIRE_WIDTH  per-port arch retire valid
commit_pc  in  RETIRE_WIDTH*ADDR_BITS  debug_pc per port (port i at [i*ADDR_BITS +: ADDR_BITS])
commit_inst  in  RETIRE_WIDTH*32  debug_inst per port
commit_rtype  in  RETIRE_WIDTH*3  dst_rtype per port (0 GPR, 1 FPR, 4 vector)
commit_ldst  in  RETIRE_WIDTH*6  logical destination per port
commit_wdata  in  RETIRE_WIDTH*XLEN  debug_wdata per port
csr_cmd  in  3  CSR command
csr_addr  in  12  CSR address
csr_wdata  in  XLEN  CSR write operand
csr_rdata  in  XLEN  CSR old value
out_valid  out  1  head entry valid
out_ready  in  1  sink accepts head
out_kind  out  1  0 retire, 1 CSR
out_cycle  out  64  cycle stamp
out_pc  out  ADDR_BITS  PC; 0 for CSR entries
out_inst  out  32  instruction; 0 for CSR entries
out_rtype  out  3  rtype; 0 for CSR entries
out_addr  out  12  ldst (zero-extended) or CSR address
out_data  out  XLEN  wdata or computed CSR value
count  out  $clog2(DEPTH+1)  occupancy
full  out  1  count == DEPTH
overflow  out  1  sticky: any group dropped since reset
drop_count  out  DROP_BITS  events dropped, saturating

Behaviour:
- Reset, synchronous and active-high, takes effect at the next clock edge. All of the following clear to 0: cycle counter, read/write pointers, count, full, overflow, drop_count, out_valid. Payload outputs are don't-care while out_valid=0.
- Reset mid-operation discards all queued entries. No partial drain.
- Cycle counter: 64-bit, +1 per non-reset cycle, wraps modulo 2^64. Every event captured in a cycle gets that cycle's pre-increment value.
- Event group per cycle, only when enable=1:
  - Retire events: one per set commit_valid bit, ordered by ascending port index.
  - CSR event: appended last when csr_cmd is 5, 6 or 7. out_data is wdata (5), rdata|wdata (6), or rdata&~wdata (7). Any other cmd produces no event.
- Group size n ranges 0..RETIRE_WIDTH+1.
- Free space: free = DEPTH - count + deq, where deq = out_valid & out_ready in the same cycle.
- Enqueue is all-or-nothing per group:
  - If n <= free: write n entries at consecutive wrapped write-pointer slots; wptr += n mod DEPTH.
  - Otherwise: write nothing, drop_count += n (saturating at all-ones), overflow <= 1.
- count_next = count + accepted_n - deq.
- enable=0: no capture and no drop accounting. Draining continues.
- Output is show-ahead: out_* reflect the entry at rptr combinationally from storage, and out_valid = (count != 0).
- Latency: an event captured in cycle t is visible on out_* in cycle t+1 at the earliest.
- Handshake: the entry is consumed on the edge where out_valid & out_ready. While out_valid=1 and out_ready=0, all out_* hold stable. out_ready while out_valid=0 is ignored.
- At most one dequeue per cycle. Simultaneous enqueue and dequeue at full is legal, counts the freed slot, and leaves count at DEPTH.
- Pointers are log2(DEPTH) bits wide and wrap naturally.

Test Plan:
1. After reset, cycle 10: commit_valid=3'b101 (pc 0x1000 and 0x1008), csr_cmd=6, rdata=0xF0, wdata=0x0F, out_ready=1. Response: three consecutive beats in order port0 pc 0x1000, port2 pc 0x1008, then CSR with data 0xFF; all three carry out_cycle=10.
2. DEPTH=16, out_ready=0, group of 4 events per cycle for 4 cycles: count=16 and full=1. Fifth group of 4: dropped, drop_count=4, overflow=1, head entry unchanged.
3. At full with out_ready=1 and a 1-event group: accepted, count stays 16. Next beat is the old second entry.
4. CSR cases: cmd 7 with rdata 0xFF, wdata 0x0F gives out_data 0xF0, out_pc 0, out_kind 1. cmd 5 passes wdata through. cmd 4 produces no entry.
5. Wrap-around: 100 random groups with random out_ready at ~60% and enable toggling. The output sequence must match a scoreboard model exactly, including drop_count and its saturation at 0xFFFF when forced with DROP_BITS=16.
6. Reset asserted with count=7 and out_valid=1: on the next cycle out_valid=0, count=0, drop_count=0, overflow=0. The first post-reset event carries cycle stamp 0.
